imem_loader: RTL and testbench

IMEM_LOADER -- requirements
Module: imem_loader

---
 rtl/imem_loader_pkg.sv | 26 ++
 rtl/word_packer.sv | 34 +++
 rtl/imem_loader.sv | 136 +++++++++++++
 tb/tb_imem_loader.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/imem_loader_pkg.sv
// Shared types and widths for the instruction-memory loader.
// IMEM_LOADER_CHECKSUM_EN adds the CHK state for a trailing XOR checksum byte.
package imem_loader_pkg;

  localparam int BYTE_W     = 8;
  localparam int WORD_W     = 32;
  localparam int WORD_BYTES = 4;

`ifdef IMEM_LOADER_CHECKSUM_EN
  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    RECV  = 3'd1,
    WRITE = 3'd2,
    CHK   = 3'd3,
    DONE  = 3'd4
  } state_t;
`else
  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    RECV  = 3'd1,
    WRITE = 3'd2,
    DONE  = 3'd4
  } state_t;
`endif

endpackage

// File: rtl/word_packer.sv
// Collects four stream bytes into one big-endian word; the first byte lands in [31:24].
module word_packer
  import imem_loader_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              clear,
  input  logic              byte_en,
  input  logic [BYTE_W-1:0] byte_in,
  output logic [WORD_W-1:0] word_next,
  output logic              word_full
);

  logic [1:0]               idx;
  logic [WORD_W-BYTE_W-1:0] shreg;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idx   <= 2'd0;
      shreg <= '0;
    end else if (clear) begin
      idx   <= 2'd0;
      shreg <= '0;
    end else if (byte_en) begin
      idx   <= idx + 2'd1;
      shreg <= {shreg[WORD_W-2*BYTE_W-1:0], byte_in};
    end
  end

  // The word is complete in the same cycle the fourth byte is handed over.
  assign word_next = {shreg, byte_in};
  assign word_full = byte_en && (idx == 2'd3);

endmodule

// File: rtl/imem_loader.sv
// Streams bytes into instruction memory while holding the core in reset.
// IMEM_LOADER_CHECKSUM_EN: expect one XOR checksum byte after the last word.
// Stream handshake: a byte transfers on a rising edge where in_valid && in_ready.
module imem_loader
  import imem_loader_pkg::*;
#(
  parameter int          DEPTH_WORDS = 256,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [15:0]       word_count,
  input  logic              in_valid,
  input  logic [BYTE_W-1:0] in_data,
  output logic              in_ready,
  output logic              mem_we,
  output logic [31:0]       mem_addr,
  output logic [WORD_W-1:0] mem_wdata,
  output logic              cpu_hold,
  output logic              busy,
  output logic              done,
  output logic              err,
  output state_t            state_dbg
);

  state_t            state, state_next;
  logic [15:0]       remaining;
  logic              start_acc;
  logic              too_big;
  logic              byte_en;
  logic [WORD_W-1:0] word_next;
  logic              word_full;

  assign start_acc = (state == IDLE) && start;
  assign too_big   = 32'(word_count) > 32'(DEPTH_WORDS);
  assign byte_en   = (state == RECV) && in_valid;
  assign state_dbg = state;

  word_packer u_packer (
    .clk       (clk),
    .rst       (rst),
    .clear     (start_acc),
    .byte_en   (byte_en),
    .byte_in   (in_data),
    .word_next (word_next),
    .word_full (word_full)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    in_ready   = 1'b0;
    mem_we     = 1'b0;
    cpu_hold   = 1'b0;
    done       = 1'b0;
    busy       = (state != IDLE);
    case (state)
      IDLE: begin
        if (start) begin
          if (word_count == 16'd0 || too_big) state_next = DONE;
          else                                state_next = RECV;
        end
      end
      RECV: begin
        in_ready = 1'b1;
        cpu_hold = 1'b1;
        if (word_full) state_next = WRITE;
      end
      WRITE: begin
        mem_we   = 1'b1;
        cpu_hold = 1'b1;
`ifdef IMEM_LOADER_CHECKSUM_EN
        state_next = (remaining > 16'd1) ? RECV : CHK;
`else
        state_next = (remaining > 16'd1) ? RECV : DONE;
`endif
      end
`ifdef IMEM_LOADER_CHECKSUM_EN
      CHK: begin
        in_ready = 1'b1;
        cpu_hold = 1'b1;
        if (in_valid) state_next = DONE;
      end
`endif
      DONE: begin
        done       = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      remaining <= '0;
      mem_addr  <= BASE_ADDR;
      mem_wdata <= '0;
    end else begin
      if (start_acc) begin
        remaining <= word_count;
        mem_addr  <= BASE_ADDR;
      end else if (state == WRITE) begin
        remaining <= remaining - 16'd1;
        mem_addr  <= mem_addr + 32'd4;
      end
      if (word_full) mem_wdata <= word_next;
    end
  end

`ifdef IMEM_LOADER_CHECKSUM_EN
  logic [BYTE_W-1:0] xor_acc;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      xor_acc <= '0;
      err     <= 1'b0;
    end else begin
      if (start_acc)    xor_acc <= '0;
      else if (byte_en) xor_acc <= xor_acc ^ in_data;
      if (start_acc) err <= too_big;
      else if (state == CHK && in_valid && in_data != xor_acc) err <= 1'b1;
    end
  end
`else
  always_ff @(posedge clk or posedge rst) begin
    if (rst)            err <= 1'b0;
    else if (start_acc) err <= too_big;
  end
`endif

endmodule

// File: tb/tb_imem_loader.sv
// Randomized scoreboard bench for imem_loader: expected writes and done/err are queued
// at stimulus time and popped by a negedge monitor.
module tb_imem_loader;
  import imem_loader_pkg::*;

  localparam logic [31:0] BASE = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [15:0] word_count;
  logic        in_valid;
  logic [7:0]  in_data;
  logic        in_ready, mem_we, cpu_hold, busy, done, err;
  logic [31:0] mem_addr, mem_wdata;
  state_t      state_dbg;

  imem_loader #(.DEPTH_WORDS(256), .BASE_ADDR(BASE)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .word_count (word_count),
    .in_valid   (in_valid),
    .in_data    (in_data),
    .in_ready   (in_ready),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .cpu_hold   (cpu_hold),
    .busy       (busy),
    .done       (done),
    .err        (err),
    .state_dbg  (state_dbg)
  );

  // clock / reset
  always #5 clk = ~clk;

  // scoreboard
  logic [63:0] exp_q[$];
  logic [0:0]  exp_err_q[$];
  logic [7:0]  pay_q[$];
  int n_checks = 0;
  int n_errors = 0;
  int ready_cycles = 0;
  int hold_viol = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, got, exp, $time);
    end
  endtask

  task automatic flag(input string name);
    n_checks++;
    n_errors++;
    $display("FAIL %s at %0t", name, $time);
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      logic [63:0] e;
      if (in_ready) ready_cycles++;
      if (busy && !done && !cpu_hold) hold_viol++;
      if (mem_we) begin
        if (exp_q.size() == 0) flag("unexpected_write");
        else begin
          e = exp_q.pop_front();
          check("wr_addr", mem_addr, e[63:32]);
          check("wr_data", mem_wdata, e[31:0]);
        end
      end
      if (done) begin
        if (exp_err_q.size() == 0) flag("unexpected_done");
        else check("done_err", {31'd0, err}, {31'd0, exp_err_q.pop_front()});
        check("done_hold", {31'd0, cpu_hold}, 32'd0);
      end
    end
  end

  // driver tasks (all begin and end just after a falling edge)
  task automatic start_session(input int wc);
    start      = 1'b1;
    word_count = 16'(wc);
    @(negedge clk);
    start      = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b, input bit stall, input bit last_of_word);
    int cnt = 0;
    in_valid = 1'b1;
    in_data  = b;
    while (!in_ready && cnt < 50) begin
      @(negedge clk);
      cnt++;
    end
    if (cnt >= 50) begin
      flag("in_ready_timeout");
      in_valid = 1'b0;
      return;
    end
    @(negedge clk);
    in_valid = 1'b0;
    if (last_of_word) check("we_latency", {31'd0, mem_we}, 32'd1);
    if (stall) @(negedge clk);
  endtask

  task automatic wait_idle();
    int cnt = 0;
    while (busy && cnt < 100) begin
      @(negedge clk);
      cnt++;
    end
    if (cnt >= 100) flag("idle_timeout");
  endtask

  // Reference model: word i lives at BASE + 4*i, bytes packed MSB first.
  task automatic run_session(input int wc, input bit stall, input bit bad_cs);
    logic [7:0]  b;
    logic [7:0]  x = 8'h00;
    logic [31:0] w;
    while (pay_q.size() < wc * 4) pay_q.push_back(8'($urandom_range(0, 255)));
`ifdef IMEM_LOADER_CHECKSUM_EN
    exp_err_q.push_back(bad_cs);
`else
    exp_err_q.push_back(1'b0);
`endif
    start_session(wc);
    for (int i = 0; i < wc; i++) begin
      w = 32'd0;
      for (int k = 0; k < 4; k++) begin
        b = pay_q.pop_front();
        x = x ^ b;
        w = (w << 8) | {24'd0, b};
        if (k == 3) exp_q.push_back({BASE + 32'(4 * i), w});
        send_byte(b, stall, k == 3);
      end
    end
`ifdef IMEM_LOADER_CHECKSUM_EN
    send_byte(bad_cs ? (x ^ 8'h01) : x, 1'b0, 1'b0);
`endif
    wait_idle();
    check("writes_drained", 32'(exp_q.size()), 32'd0);
    check("done_drained", 32'(exp_err_q.size()), 32'd0);
    check("hold_after", {31'd0, cpu_hold}, 32'd0);
  endtask

  initial begin
    logic [7:0] b;
    rst = 1'b1;
    start = 1'b0;
    word_count = 16'd0;
    in_valid = 1'b0;
    in_data = 8'h00;
    repeat (3) @(negedge clk);
    check("rst_in_ready", {31'd0, in_ready}, 32'd0);
    check("rst_mem_we",   {31'd0, mem_we}, 32'd0);
    check("rst_cpu_hold", {31'd0, cpu_hold}, 32'd0);
    check("rst_busy",     {31'd0, busy}, 32'd0);
    check("rst_done",     {31'd0, done}, 32'd0);
    check("rst_err",      {31'd0, err}, 32'd0);
    check("rst_mem_addr", mem_addr, BASE);
    check("rst_mem_wdata", mem_wdata, 32'd0);
    rst = 1'b0;
    @(negedge clk);
    check("idle_done", {31'd0, done}, 32'd0);

    // two directed words
    pay_q = '{8'h20, 8'h08, 8'h00, 8'h05, 8'h00, 8'h00, 8'h00, 8'h0C};
    run_session(2, 1'b0, 1'b0);

    // stalled single word
    hold_viol = 0;
    pay_q = '{8'hDE, 8'hAD, 8'hBE, 8'hEF};
    run_session(1, 1'b1, 1'b0);
    check("stall_hold", 32'(hold_viol), 32'd0);

    // empty session
    exp_err_q.push_back(1'b0);
    start_session(0);
    check("zero_done", {31'd0, done}, 32'd1);
    @(negedge clk);
    check("zero_idle", {31'd0, busy}, 32'd0);

    // oversize session
    ready_cycles = 0;
    exp_err_q.push_back(1'b1);
    start_session(257);
    check("big_done", {31'd0, done}, 32'd1);
    wait_idle();
    check("big_no_ready", 32'(ready_cycles), 32'd0);
    check("big_err_sticky", {31'd0, err}, 32'd1);
    check("big_no_write", 32'(exp_q.size()), 32'd0);

    // next good session clears err
    run_session(1, 1'b0, 1'b0);

    // reset mid-load: 6 of 8 bytes then reset
    start_session(2);
    for (int k = 0; k < 6; k++) begin
      b = 8'($urandom_range(0, 255));
      pay_q.push_back(b);
      if (k == 3) exp_q.push_back({BASE, pay_q[0], pay_q[1], pay_q[2], pay_q[3]});
      send_byte(b, 1'b0, k == 3);
    end
    pay_q.delete();
    rst = 1'b1;
    @(negedge clk);
    check("abort_busy", {31'd0, busy}, 32'd0);
    check("abort_addr", mem_addr, BASE);
    check("abort_hold", {31'd0, cpu_hold}, 32'd0);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    check("abort_writes", 32'(exp_q.size()), 32'd0);
    run_session(1, 1'b0, 1'b0);

    // checksum directed cases (plain loads when the checksum is compiled out)
    pay_q = '{8'h01, 8'h02, 8'h03, 8'h04};
    run_session(1, 1'b0, 1'b0);
    pay_q = '{8'h01, 8'h02, 8'h03, 8'h04};
    run_session(1, 1'b0, 1'b1);

    // random sessions
    for (int s = 0; s < 10; s++)
      run_session($urandom_range(1, 5), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));

    repeat (3) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
